// File: rtl/mandala_layer_pipeline_if.sv
// Pixel-side bundle for the mandala engine: coordinates, sync sideband,
// animation controls in; colour, delayed syncs and status out.
interface mandala_layer_pipeline_if;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        display_on;
  logic        hsync_in;
  logic        vsync_in;
  logic [1:0]  speed;
  logic        reverse;
  logic        pause;
  logic [1:0]  r;
  logic [1:0]  g;
  logic [1:0]  b;
  logic        hsync_out;
  logic        vsync_out;
  logic        display_out;
  logic [3:0]  layer_out;
  logic [7:0]  phase;
  logic [15:0] frame_cnt;

  modport master (
    output pix_x, pix_y, display_on,
    output hsync_in, vsync_in,
    output speed, reverse, pause,
    input  r, g, b,
    input  hsync_out, vsync_out, display_out,
    input  layer_out, phase, frame_cnt
  );

  modport slave (
    input  pix_x, pix_y, display_on,
    input  hsync_in, vsync_in,
    input  speed, reverse, pause,
    output r, g, b,
    output hsync_out, vsync_out, display_out,
    output layer_out, phase, frame_cnt
  );
endinterface

// File: rtl/mandala_layer_pipeline.sv
// Three-stage mandala pixel engine: distance, squares/angle, ring + colour.
// Sync sideband travels alongside so outputs stay aligned.
module mandala_layer_pipeline #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int NUM_LAYERS = 8,
  parameter int RING_STEP  = 20000
) (
  input  logic                     clk,
  input  logic                     reset,
  mandala_layer_pipeline_if.slave  bus
);

  localparam logic [9:0] CX = 10'(H_RES / 2);
  localparam logic [9:0] CY = 10'(V_RES / 2);

  typedef struct packed {
    logic [9:0] dx;
    logic [9:0] dy;
    logic       hs;
    logic       vs;
    logic       de;
  } s1_t;

  typedef struct packed {
    logic [19:0] dx2;
    logic [19:0] dy2;
    logic [7:0]  angle;
    logic        hs;
    logic        vs;
    logic        de;
  } s2_t;

  s1_t s1;
  s2_t s2;

  logic [7:0]  phase_q;
  logic [7:0]  ccnt;
  logic [15:0] frame_q;
  logic        vs_prev;

  logic [5:0]  rgb_q;
  logic [3:0]  lay_q;
  logic        hs_q;
  logic        vs_q;
  logic        de_q;

  logic [9:0]  dx_c;
  logic [9:0]  dy_c;
  logic [19:0] rad;
  logic [3:0]  lay_c;
  logic        hit_c;
  logic        on_c;
  logic [5:0]  tint_c;
  logic [5:0]  col_c;
  logic        edge_c;
  logic [7:0]  step_c;

  always_comb begin
    dx_c = (bus.pix_x >= CX) ? bus.pix_x - CX : CX - bus.pix_x;
    dy_c = (bus.pix_y >= CY) ? bus.pix_y - CY : CY - bus.pix_y;
  end

  // Descending scan leaves the lowest ring whose upper bound exceeds rad.
  always_comb begin
    rad    = s2.dx2 + s2.dy2;
    lay_c  = 4'hF;
    hit_c  = 1'b0;
    on_c   = 1'b0;
    tint_c = 6'd0;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (32'(rad) < (k + 1) * RING_STEP) begin
        lay_c  = 4'(k);
        hit_c  = 1'b1;
        on_c   = s2.angle[k % 8] ^ s2.angle[(k + 3) % 8];
        tint_c = 6'(((k + 1) * 21) % 64);
      end
    end
    col_c = ccnt[7:2] + tint_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      rgb_q <= '0;
      lay_q <= 4'hF;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      de_q  <= 1'b0;
    end else begin
      s1.dx    <= dx_c;
      s1.dy    <= dy_c;
      s1.hs    <= bus.hsync_in;
      s1.vs    <= bus.vsync_in;
      s1.de    <= bus.display_on;
      s2.dx2   <= 20'(s1.dx) * 20'(s1.dx);
      s2.dy2   <= 20'(s1.dy) * 20'(s1.dy);
      s2.angle <= (s1.dx[7:0] ^ s1.dy[7:0]) + phase_q;
      s2.hs    <= s1.hs;
      s2.vs    <= s1.vs;
      s2.de    <= s1.de;
      rgb_q    <= (s2.de && hit_c && on_c) ? col_c : 6'd0;
      lay_q    <= s2.de ? lay_c : 4'hF;
      hs_q     <= s2.hs;
      vs_q     <= s2.vs;
      de_q     <= s2.de;
    end
  end

  assign edge_c = bus.vsync_in & ~vs_prev;
  assign step_c = 8'(bus.speed) + 8'd1;

  // vs_prev resets high so a vsync held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_prev <= 1'b1;
      phase_q <= 8'd0;
      ccnt    <= 8'd0;
      frame_q <= 16'd0;
    end else begin
      vs_prev <= bus.vsync_in;
      if (edge_c) begin
        frame_q <= frame_q + 16'd1;
        if (!bus.pause) begin
          phase_q <= bus.reverse ? phase_q - step_c
                                 : phase_q + step_c;
          ccnt    <= ccnt + 8'd1;
        end
      end
    end
  end

  assign bus.r           = rgb_q[5:4];
  assign bus.g           = rgb_q[3:2];
  assign bus.b           = rgb_q[1:0];
  assign bus.hsync_out   = hs_q;
  assign bus.vsync_out   = vs_q;
  assign bus.display_out = de_q;
  assign bus.layer_out   = lay_q;
  assign bus.phase       = phase_q;
  assign bus.frame_cnt   = frame_q;

endmodule
